shift_collect: RTL and testbench
================================

SHIFT_COLLECT -- requirements
Module: shift_collect

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous, active-low reset).
REQ-002 ser_valid  input  1  SHALL mean a serial bit is offered this cycle.
REQ-003 ser_data  input  1  SHALL carry the offered serial bit.
REQ-004 ser_ready  output  1  SHALL mean the block accepts the bit this cycle; a bit is taken only when ser_valid && ser_ready.
REQ-005 dir  input  1  SHALL select the bit order: 0 = LSB-first, 1 = MSB-first. It is sampled with the first bit of each word.
REQ-006 flush  input  1  SHALL be a synchronous abort that discards any partial or completed word.
REQ-007 par_data  output  6  SHALL be the assembled word.
REQ-008 par_valid  output  1  SHALL mean par_data holds a complete word.
REQ-009 par_ready  input  1  SHALL mean the consumer takes the word; the word is transferred when par_valid && par_ready.
REQ-010 busy  output  1  SHALL be high when a word is partly assembled (state SHIFT).
REQ-011 parity_err  output  1  SHALL flag a parity mismatch, qualified by par_valid.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and FULL, with a 3-bit bit counter cnt.
REQ-013 ser_ready SHALL be (state != FULL || par_ready) && !flush.
REQ-014 In IDLE, an accepted bit SHALL latch dir into dir_q, load the first bit, set cnt=1 and move the FSM to SHIFT.
REQ-015 When dir_q=0, each accepted bit SHALL shift par_data right (bit i <= bit i+1) and enter at bit 5, so the first bit ends at bit 0.
REQ-016 When dir_q=1, each accepted bit SHALL shift par_data left and enter at bit 0, so the first bit ends at bit 5.
REQ-017 On the accept that completes the word (cnt reaching WLEN-1), the FSM SHALL enter FULL; par_valid SHALL be high on the next cycle (one-cycle latency from the last bit).
REQ-018 WLEN SHALL be 6, or 7 when the parity option is compiled in.
REQ-019 In FULL, par_data and parity_err SHALL hold stable until the word is transferred.
REQ-020 On a word transfer with no bit accepted in the same cycle, the FSM SHALL go to IDLE.
REQ-021 On a word transfer with a bit accepted in the same cycle, that bit SHALL start the next word: dir is sampled, cnt=1, and the FSM goes to SHIFT. Back-to-back words SHALL lose no cycles.
REQ-022 cnt SHALL never wrap inside a word; cnt SHALL be cleared on entry to IDLE or FULL.
REQ-023 flush SHALL have priority over every other event: the FSM goes to IDLE, cnt=0, par_valid=0 and parity_err=0 on the next cycle, and par_data holds its value.
REQ-024 A bit offered while flush is high SHALL NOT be accepted (ser_ready is low).
REQ-025 dir changes in the middle of a word SHALL be ignored until the next word starts.

Reset
REQ-026 While rst_n is low, independent of clk, the FSM SHALL be IDLE, cnt=0, dir_q=0, par_data=6'b000000, par_valid=0, busy=0 and parity_err=0.
REQ-027 Reset asserted in the middle of a word SHALL discard the partial word; after release, the first accepted bit SHALL start a new word.
REQ-028 ser_ready SHALL be 1 after reset unless flush is high.

Configuration
REQ-029 The parity option SHALL be controlled by the macro SHIFT_COLLECT_PARITY_EN.
REQ-030 With SHIFT_COLLECT_PARITY_EN defined, the 7th serial bit of each word SHALL be an even-parity bit over the 6 data bits. It is not stored in par_data. parity_err SHALL be set to 1 when XOR(data, parity bit) is 1, and SHALL be valid with par_valid.
REQ-031 With SHIFT_COLLECT_PARITY_EN undefined, the word SHALL be 6 bits and parity_err SHALL be tied to 0.

Verification
REQ-032 LSB-first: dir=0, bits 1,1,0,1,0,1 on consecutive cycles -> par_valid one cycle after the 6th bit, par_data=6'b101011.
REQ-033 MSB-first: dir=1, same bits -> par_data=6'b110101; dir toggled to 0 after bit 2 -> result unchanged.
REQ-034 Backpressure: word complete, par_ready=0 for 3 cycles with ser_valid=1 -> ser_ready=0 and par_data stable. par_ready=1 with ser_valid=1 -> word transferred, that bit is the first of the next word, busy=1.
REQ-035 Flush/reset: flush after 3 bits -> IDLE, busy=0. rst_n low after 4 bits of a later word -> all outputs are at reset values. A following word 0,0,0,0,0,1 (dir=0) -> 6'b100000.
REQ-036 Parity (macro defined): dir=0, data 1,1,0,1,0,1 + parity 0 -> par_data=6'b101011, parity_err=0. Same data with parity 1 -> parity_err=1.

Source files
------------

// File: rtl/shift_collect.sv
// shift_collect: serial-to-parallel collector for 6-bit words.
// Bits arrive on a valid/ready serial port, LSB-first or MSB-first as selected
// by dir at the first bit of each word. The finished word is presented on a
// valid/ready parallel port.
// Optional feature macro: SHIFT_COLLECT_PARITY_EN adds a 7th serial bit per word
// (even parity over the 6 data bits), reported through parity_err.
module shift_collect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_valid,
    input  logic       ser_data,
    output logic       ser_ready,
    input  logic       dir,
    input  logic       flush,
    output logic [5:0] par_data,
    output logic       par_valid,
    input  logic       par_ready,
    output logic       busy,
    output logic       parity_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

`ifdef SHIFT_COLLECT_PARITY_EN
    localparam int WLEN = 7;
`else
    localparam int WLEN = 6;
`endif
    localparam logic [2:0] CNT_LAST = 3'(WLEN - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic [5:0] data_q, data_d;

    logic       accept;
    logic       start;
    logic       dir_eff;
    logic [5:0] shifted;

    // Handshake decode and the shifted word for the current accept
    always_comb begin
        ser_ready = ((state_q != S_FULL) || par_ready) && !flush;
        accept    = ser_valid && ser_ready;
        // An accept outside SHIFT always opens a new word; in FULL it can only
        // happen together with the transfer, since ser_ready needs par_ready.
        start     = accept && (state_q != S_SHIFT);
        dir_eff   = start ? dir : dir_q;
        shifted   = dir_eff ? {data_q[4:0], ser_data} : {ser_data, data_q[5:1]};
    end

`ifdef SHIFT_COLLECT_PARITY_EN
    logic perr_q, perr_d;

    // Parity flag is computed when the parity bit (7th) arrives
    always_comb begin
        perr_d = perr_q;
        if (flush) begin
            perr_d = 1'b0;
        end else if (state_q == S_SHIFT && accept && cnt_q == CNT_LAST) begin
            perr_d = (^data_q) ^ ser_data;
        end
    end

    // Parity flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // Next-state logic: flush overrides everything, par_data is never cleared by it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        data_d  = data_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dir_d   = dir;
                        data_d  = shifted;
                        cnt_d   = 3'd1;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (accept) begin
`ifdef SHIFT_COLLECT_PARITY_EN
                        // The parity bit is consumed but never stored
                        if (cnt_q != CNT_LAST) begin
                            data_d = shifted;
                        end
`else
                        data_d = shifted;
`endif
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = 3'd0;
                            state_d = S_FULL;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                S_FULL: begin
                    if (par_ready) begin
                        if (start) begin
                            dir_d   = dir;
                            data_d  = shifted;
                            cnt_d   = 3'd1;
                            state_d = S_SHIFT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            dir_q   <= 1'b0;
            data_q  <= 6'b000000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
        end
    end

    assign par_data  = data_q;
    assign par_valid = (state_q == S_FULL);
    assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_shift_collect.sv
// Testbench for shift_collect: directed words with hand-computed results.
// Expected words go into a scoreboard queue; a monitor pops and compares on
// every parallel-port transfer. Honours SHIFT_COLLECT_PARITY_EN if defined.
module tb_shift_collect;

`ifdef SHIFT_COLLECT_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_data = 1'b0;
    logic       ser_ready;
    logic       dir = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] par_data;
    logic       par_valid;
    logic       par_ready = 1'b1;
    logic       busy;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] d;
        logic       e;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    shift_collect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .dir       (dir),
        .flush     (flush),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .busy      (busy),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic exp_err(input logic [5:0] s, input logic p);
        return PAR_EN ? ((^s) ^ p) : 1'b0;
    endfunction

    // Monitor: every parallel transfer must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && par_valid && par_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %b expected none", par_data);
            end else begin
                mon_e = sb.pop_front();
                chk("word_data", 32'(par_data), 32'(mon_e.d));
                chk("word_perr", 32'(parity_err), 32'(mon_e.e));
            end
        end
    end

    // Offer one bit; returns #1 after the edge that accepted it
    task automatic send_bit(input logic b, input logic d);
        int n;
        n = 0;
        ser_valid = 1'b1;
        ser_data  = b;
        dir       = d;
        @(negedge clk);
        while (!ser_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!ser_ready) begin
            checks++;
            errors++;
            $display("FAIL ser_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
    endtask

    // seq[0] is sent first; dm[i] is the dir value shown with bit i
    task automatic send_word(input logic [5:0] seq, input logic [5:0] dm, input logic pbit);
        for (int i = 0; i < 6; i++) send_bit(seq[i], dm[i]);
        if (PAR_EN) send_bit(pbit, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst_n is low
        #12;
        chk("rst_par_data", 32'(par_data), 32'h00);
        chk("rst_par_valid", 32'(par_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_ser_ready", 32'(ser_ready), 32'h1);

        // LSB-first 1,1,0,1,0,1 -> 101011
        sb.push_back('{6'b101011, exp_err(6'b101011, 1'b0)});
        send_word(6'b101011, 6'b000000, 1'b0);
        chk("lsb_valid_latency", 32'(par_valid), 32'h1);
        @(posedge clk); #1;
        chk("lsb_valid_drop", 32'(par_valid), 32'h0);

        // MSB-first same bits, dir dropped to 0 after bit 2 -> 110101
        sb.push_back('{6'b110101, exp_err(6'b101011, 1'b0)});
        send_word(6'b101011, 6'b000011, 1'b0);
        chk("msb_valid", 32'(par_valid), 32'h1);
        @(posedge clk); #1;

        // Backpressure: bits 0,1,1,0,0,1 LSB-first -> 100110 held in FULL
        par_ready = 1'b0;
        sb.push_back('{6'b100110, exp_err(6'b100110, 1'b1)});
        send_word(6'b100110, 6'b000000, 1'b1);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        dir       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ser_ready", 32'(ser_ready), 32'h0);
            chk("bp_par_data", 32'(par_data), 32'h26);
            chk("bp_par_valid", 32'(par_valid), 32'h1);
        end
        @(posedge clk); #1;
        par_ready = 1'b1;
        // Overlapped bit starts next word 1,0,0,0,0,0 -> 000001
        sb.push_back('{6'b000001, exp_err(6'b000001, 1'b1)});
        @(negedge clk);
        chk("bp_release_ready", 32'(ser_ready), 32'h1);
        @(posedge clk); #1;
        chk("bp_next_busy", 32'(busy), 32'h1);
        chk("bp_next_valid", 32'(par_valid), 32'h0);
        for (int i = 1; i < 6; i++) send_bit(1'b0, 1'b0);
        if (PAR_EN) send_bit(1'b1, 1'b0);
        chk("bp_next_done", 32'(par_valid), 32'h1);
        @(posedge clk); #1;

        // Flush after 3 bits
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("fl_busy_before", 32'(busy), 32'h1);
        flush     = 1'b1;
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        @(negedge clk);
        chk("fl_ser_ready", 32'(ser_ready), 32'h0);
        @(posedge clk); #1;
        flush     = 1'b0;
        ser_valid = 1'b0;
        chk("fl_busy_after", 32'(busy), 32'h0);
        chk("fl_valid_after", 32'(par_valid), 32'h0);

        // Flush a completed word (wrong parity if enabled): data held, flags cleared
        par_ready = 1'b0;
        send_word(6'b111000, 6'b000000, 1'b0);
        chk("flf_valid", 32'(par_valid), 32'h1);
`ifdef SHIFT_COLLECT_PARITY_EN
        chk("flf_perr_before", 32'(parity_err), 32'h1);
`endif
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flf_valid_after", 32'(par_valid), 32'h0);
        chk("flf_perr_after", 32'(parity_err), 32'h0);
        chk("flf_data_held", 32'(par_data), 32'h38);
        par_ready = 1'b1;

        // Asynchronous reset after 4 MSB-first bits
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        chk("rs_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rs_par_data", 32'(par_data), 32'h00);
        chk("rs_par_valid", 32'(par_valid), 32'h0);
        chk("rs_busy", 32'(busy), 32'h0);
        chk("rs_parity_err", 32'(parity_err), 32'h0);
        chk("rs_ser_ready", 32'(ser_ready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 0,0,0,0,0,1 LSB-first -> 100000
        sb.push_back('{6'b100000, exp_err(6'b100000, 1'b1)});
        send_word(6'b100000, 6'b000000, 1'b1);
        @(posedge clk); #1;

`ifdef SHIFT_COLLECT_PARITY_EN
        // Wrong parity bit on 101011 -> parity_err=1
        sb.push_back('{6'b101011, 1'b1});
        send_word(6'b101011, 6'b000000, 1'b1);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
